// File: rtl/joy_resolve.sv
// joy_resolve: per-channel joystick conditioning.
// Each direction and fire bit is synchronised, debounced and registered.
// Opposite directions on one axis are resolved according to mode.
// An optional 4-way filter suppresses diagonals.
// Optional autofire is compiled in when JOY_AUTOFIRE_EN is defined; it adds the af_en port.
module joy_resolve #(
  parameter int NUM_CH     = 2,
  parameter int DEB_CYCLES = 240,
  parameter int AF_HALF    = 1200000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic                  four_way,
  input  logic [4*NUM_CH-1:0]   dir_in,
  input  logic [NUM_CH-1:0]     fire_in,
`ifdef JOY_AUTOFIRE_EN
  input  logic [NUM_CH-1:0]     af_en,
`endif
  output logic [4*NUM_CH-1:0]   dir_out,
  output logic [NUM_CH-1:0]     fire_out
);

  // Debounced bits: directions first, then one fire bit per channel at FB + n
  localparam int NB = 5 * NUM_CH;
  localparam int FB = 4 * NUM_CH;
  localparam int CW = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LIM = CW'(DEB_CYCLES);

  logic [NB-1:0]         raw_s;
  logic [NB-1:0]         sync1_q, sync2_q;
  logic [NB-1:0]         deb_q, deb_d;
  logic [NB-1:0][CW-1:0] cnt_q, cnt_d;

  // Records: last_h 1=R / 0=L, last_v 1=U / 0=D, axis_h 1=H / 0=V
  logic [NUM_CH-1:0]     last_h_q, last_h_d;
  logic [NUM_CH-1:0]     last_v_q, last_v_d;
  logic [NUM_CH-1:0]     axis_h_q, axis_h_d;

  logic [4*NUM_CH-1:0]   dir_res_s;
  logic [NUM_CH-1:0]     fire_res_s;
  logic [4*NUM_CH-1:0]   dir_q;
  logic [NUM_CH-1:0]     fire_q;

  assign raw_s = {fire_in, dir_in};

  // Debounce: adopt the synchronised value once it has differed long enough
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] >= DEB_LIM) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Rising-edge records and opposite-direction / 4-way resolution
  always_comb begin : resolve_p
    logic rr, rl, rd, ru;
    logic hr, hl, vd, vu;
    dir_res_s = '0;
    last_h_d  = last_h_q;
    last_v_d  = last_v_q;
    axis_h_d  = axis_h_q;
    for (int n = 0; n < NUM_CH; n++) begin
      rr = deb_d[4*n+0] & ~deb_q[4*n+0];
      rl = deb_d[4*n+1] & ~deb_q[4*n+1];
      rd = deb_d[4*n+2] & ~deb_q[4*n+2];
      ru = deb_d[4*n+3] & ~deb_q[4*n+3];

      // A tie within an axis favours R / U
      if (rr) begin
        last_h_d[n] = 1'b1;
      end else if (rl) begin
        last_h_d[n] = 1'b0;
      end else begin
        last_h_d[n] = last_h_q[n];
      end
      if (ru) begin
        last_v_d[n] = 1'b1;
      end else if (rd) begin
        last_v_d[n] = 1'b0;
      end else begin
        last_v_d[n] = last_v_q[n];
      end
      // A tie between axes favours H
      if (rr | rl) begin
        axis_h_d[n] = 1'b1;
      end else if (ru | rd) begin
        axis_h_d[n] = 1'b0;
      end else begin
        axis_h_d[n] = axis_h_q[n];
      end

      hr = deb_q[4*n+0];
      hl = deb_q[4*n+1];
      vd = deb_q[4*n+2];
      vu = deb_q[4*n+3];

      if (hr && hl) begin
        case (mode)
          2'b00:   begin hr = last_h_q[n];  hl = ~last_h_q[n]; end
          2'b01:   begin hr = ~last_h_q[n]; hl = last_h_q[n];  end
          2'b10:   begin hr = 1'b0;         hl = 1'b0;         end
          default: begin hr = 1'b1;         hl = 1'b1;         end
        endcase
      end else begin
        hr = deb_q[4*n+0];
        hl = deb_q[4*n+1];
      end
      if (vu && vd) begin
        case (mode)
          2'b00:   begin vu = last_v_q[n];  vd = ~last_v_q[n]; end
          2'b01:   begin vu = ~last_v_q[n]; vd = last_v_q[n];  end
          2'b10:   begin vu = 1'b0;         vd = 1'b0;         end
          default: begin vu = 1'b1;         vd = 1'b1;         end
        endcase
      end else begin
        vu = deb_q[4*n+3];
        vd = deb_q[4*n+2];
      end

      // Diagonal in 4-way: keep only the axis that moved most recently
      if (four_way && (mode != 2'b11) && (hr | hl) && (vu | vd)) begin
        if (axis_h_q[n]) begin
          vu = 1'b0;
          vd = 1'b0;
        end else begin
          hr = 1'b0;
          hl = 1'b0;
        end
      end else begin
        hr = hr;
        hl = hl;
      end

      dir_res_s[4*n +: 4] = {vu, vd, hl, hr};
    end
  end

`ifdef JOY_AUTOFIRE_EN
  localparam int AW = (AF_HALF <= 1) ? 1 : $clog2(AF_HALF);
  localparam logic [AW-1:0] AF_LIM = AW'(AF_HALF - 1);

  logic [NUM_CH-1:0]         phase_q, phase_d;
  logic [NUM_CH-1:0][AW-1:0] af_cnt_q, af_cnt_d;

  // Autofire phase: first shot on press, toggle every AF_HALF, idle when released
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      phase_d[n]  = phase_q[n];
      af_cnt_d[n] = '0;
      if (!deb_d[FB+n]) begin
        phase_d[n]  = 1'b0;
        af_cnt_d[n] = '0;
      end else if (!deb_q[FB+n]) begin
        phase_d[n]  = 1'b1;
        af_cnt_d[n] = '0;
      end else if (af_cnt_q[n] == AF_LIM) begin
        phase_d[n]  = ~phase_q[n];
        af_cnt_d[n] = '0;
      end else begin
        af_cnt_d[n] = af_cnt_q[n] + AW'(1);
      end
      fire_res_s[n] = deb_q[FB+n] & (af_en[n] ? phase_q[n] : 1'b1);
    end
  end

  // Autofire state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q  <= '0;
      af_cnt_q <= '0;
    end else begin
      phase_q  <= phase_d;
      af_cnt_q <= af_cnt_d;
    end
  end
`else
  logic unused_af_s;
  assign unused_af_s = (AF_HALF != 0);

  // Plain fire: debounced value straight to the output register
  always_comb begin
    fire_res_s = deb_q[FB +: NUM_CH];
  end
`endif

  // Synchronisers, debounce state, records and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      cnt_q    <= '0;
      last_h_q <= '1;
      last_v_q <= '1;
      axis_h_q <= '1;
      dir_q    <= '0;
      fire_q   <= '0;
    end else begin
      sync1_q  <= raw_s;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      last_h_q <= last_h_d;
      last_v_q <= last_v_d;
      axis_h_q <= axis_h_d;
      dir_q    <= dir_res_s;
      fire_q   <= fire_res_s;
    end
  end

  assign dir_out  = dir_q;
  assign fire_out = fire_q;

endmodule

// File: tb/tb_joy_resolve.sv
// Directed bench for joy_resolve (DEB_CYCLES=4, NUM_CH=2, AF_HALF=8).
// Inputs change 1 ns after a rising edge; the next edge is the sampling edge,
// so a change shows up 8 ticks after it is applied (sampling edge + 7).
module tb_joy_resolve;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       four_way;
  logic [7:0] dir_in;
  logic [1:0] fire_in;
`ifdef JOY_AUTOFIRE_EN
  logic [1:0] af_en;
`endif
  logic [7:0] dir_out;
  logic [1:0] fire_out;

  int checks = 0;
  int errors = 0;

  joy_resolve #(.NUM_CH(2), .DEB_CYCLES(4), .AF_HALF(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .four_way (four_way),
    .dir_in   (dir_in),
    .fire_in  (fire_in),
`ifdef JOY_AUTOFIRE_EN
    .af_en    (af_en),
`endif
    .dir_out  (dir_out),
    .fire_out (fire_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 2'b00; four_way = 1'b0; dir_in = 8'h00; fire_in = 2'b00;
`ifdef JOY_AUTOFIRE_EN
    af_en = 2'b00;
`endif
    #2;
    checks++;
    if (dir_out !== 8'h00 || fire_out !== 2'b00) begin
      $display("FAIL reset_state: dir_out=%h fire_out=%b expected 00 00", dir_out, fire_out); errors++;
    end
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_latency_glitch();
    dir_in = 8'h01;
    tick(7);
    checks++;
    if (dir_out !== 8'h00) begin $display("FAIL latency_early: dir_out=%h expected 00", dir_out); errors++; end
    tick(1);
    checks++;
    if (dir_out !== 8'h01) begin $display("FAIL latency_exact: dir_out=%h expected 01", dir_out); errors++; end
    dir_in = 8'h03;
    tick(3);
    dir_in = 8'h01;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      checks++;
      if (dir_out !== 8'h01) begin $display("FAIL glitch_reject: dir_out=%h expected 01", dir_out); errors++; end
    end
    dir_in = 8'h00;
    tick(8);
    checks++;
    if (dir_out !== 8'h00) begin $display("FAIL release: dir_out=%h expected 00", dir_out); errors++; end
  endtask

  task automatic test_opposing(input logic [1:0] m, input logic [7:0] exp, input string nm);
    mode = m;
    dir_in = 8'h01;
    tick(12);
    checks++;
    if (dir_out !== 8'h01) begin $display("FAIL %s_hold_r: dir_out=%h expected 01", nm, dir_out); errors++; end
    dir_in = 8'h03;
    tick(7);
    checks++;
    if (dir_out !== 8'h01) begin $display("FAIL %s_before_l: dir_out=%h expected 01", nm, dir_out); errors++; end
    tick(1);
    checks++;
    if (dir_out !== exp) begin $display("FAIL %s_both: dir_out=%h expected %h", nm, dir_out, exp); errors++; end
    dir_in = 8'h01;
    tick(7);
    checks++;
    if (dir_out !== exp) begin $display("FAIL %s_release_early: dir_out=%h expected %h", nm, dir_out, exp); errors++; end
    tick(1);
    checks++;
    if (dir_out !== 8'h01) begin $display("FAIL %s_r_returns: dir_out=%h expected 01", nm, dir_out); errors++; end
    dir_in = 8'h00;
    tick(10);
    mode = 2'b00;
  endtask

  task automatic test_tie();
    mode = 2'b00;
    dir_in = 8'h03;
    tick(8);
    checks++;
    if (dir_out !== 8'h01) begin $display("FAIL tie_h: dir_out=%h expected 01", dir_out); errors++; end
    dir_in = 8'h0C;
    tick(8);
    checks++;
    if (dir_out !== 8'h08) begin $display("FAIL tie_v: dir_out=%h expected 08", dir_out); errors++; end
    dir_in = 8'h00;
    tick(10);
  endtask

  task automatic test_four_way();
    four_way = 1'b1; mode = 2'b00;
    dir_in = 8'h08;
    tick(10);
    checks++;
    if (dir_out !== 8'h08) begin $display("FAIL fw_hold_u: dir_out=%h expected 08", dir_out); errors++; end
    dir_in = 8'h09;
    tick(8);
    checks++;
    if (dir_out !== 8'h01) begin $display("FAIL fw_press_r: dir_out=%h expected 01", dir_out); errors++; end
    dir_in = 8'h08;
    tick(8);
    checks++;
    if (dir_out !== 8'h08) begin $display("FAIL fw_u_returns: dir_out=%h expected 08", dir_out); errors++; end
    dir_in = 8'h00;
    tick(10);
    dir_in = 8'h09;
    tick(8);
    checks++;
    if (dir_out !== 8'h01) begin $display("FAIL fw_simul: dir_out=%h expected 01", dir_out); errors++; end
    mode = 2'b11;
    tick(1);
    checks++;
    if (dir_out !== 8'h09) begin $display("FAIL fw_mode11: dir_out=%h expected 09", dir_out); errors++; end
    mode = 2'b00;
    tick(1);
    checks++;
    if (dir_out !== 8'h01) begin $display("FAIL fw_mode_back: dir_out=%h expected 01", dir_out); errors++; end
    four_way = 1'b0;
    tick(1);
    checks++;
    if (dir_out !== 8'h09) begin $display("FAIL fw_off: dir_out=%h expected 09", dir_out); errors++; end
    dir_in = 8'h00;
    tick(10);
  endtask

  task automatic test_channels();
    dir_in = 8'h23;
    tick(8);
    checks++;
    if (dir_out !== 8'h21) begin $display("FAIL ch_both: dir_out=%h expected 21", dir_out); errors++; end
    dir_in = 8'h03;
    tick(8);
    checks++;
    if (dir_out !== 8'h01) begin $display("FAIL ch1_release: dir_out=%h expected 01", dir_out); errors++; end
    dir_in = 8'h00;
    tick(10);
  endtask

  task automatic test_fire();
    fire_in = 2'b01;
    tick(7);
    checks++;
    if (fire_out !== 2'b00) begin $display("FAIL fire_early: fire_out=%b expected 00", fire_out); errors++; end
    tick(1);
    checks++;
    if (fire_out !== 2'b01) begin $display("FAIL fire_press: fire_out=%b expected 01", fire_out); errors++; end
    fire_in = 2'b00;
    tick(7);
    checks++;
    if (fire_out !== 2'b01) begin $display("FAIL fire_release_early: fire_out=%b expected 01", fire_out); errors++; end
    tick(1);
    checks++;
    if (fire_out !== 2'b00) begin $display("FAIL fire_release: fire_out=%b expected 00", fire_out); errors++; end
    tick(4);
  endtask

`ifdef JOY_AUTOFIRE_EN
  task automatic test_autofire();
    logic [1:0] exp;
    int e;
    af_en = 2'b01;
    fire_in = 2'b11;
    for (int j = 1; j <= 40; j++) begin
      tick(1);
      e = j - 1;
      exp[1] = (e >= 7);
      exp[0] = (e >= 7) && ((((e - 7) / 8) % 2) == 0);
      checks++;
      if (fire_out !== exp) begin $display("FAIL autofire_t%0d: fire_out=%b expected %b", j, fire_out, exp); errors++; end
    end
    fire_in = 2'b00;
    tick(8);
    checks++;
    if (fire_out !== 2'b00) begin $display("FAIL autofire_release: fire_out=%b expected 00", fire_out); errors++; end
    af_en = 2'b00;
    tick(4);
  endtask
`endif

  task automatic test_mid_reset();
    dir_in = 8'h01;
    tick(12);
    checks++;
    if (dir_out !== 8'h01) begin $display("FAIL rst_pre: dir_out=%h expected 01", dir_out); errors++; end
    reset = 1'b1;
    #1;
    checks++;
    if (dir_out !== 8'h00) begin $display("FAIL rst_immediate: dir_out=%h expected 00", dir_out); errors++; end
    tick(2);
    reset = 1'b0;
    tick(7);
    checks++;
    if (dir_out !== 8'h00) begin $display("FAIL rst_after_early: dir_out=%h expected 00", dir_out); errors++; end
    tick(1);
    checks++;
    if (dir_out !== 8'h01) begin $display("FAIL rst_after: dir_out=%h expected 01", dir_out); errors++; end
    dir_in = 8'h00;
    tick(10);
  endtask

  initial begin
    test_reset();
    test_latency_glitch();
    test_opposing(2'b00, 8'h02, "mode00");
    test_opposing(2'b01, 8'h01, "mode01");
    test_opposing(2'b10, 8'h00, "mode10");
    test_opposing(2'b11, 8'h03, "mode11");
    test_tie();
    test_four_way();
    test_channels();
    test_fire();
`ifdef JOY_AUTOFIRE_EN
    test_autofire();
`endif
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
